// File: rtl/tmds_encoder.sv
// DVI 1.0 TMDS 8b/10b encoder: blue/green/red channels, 2-stage pipeline, per-channel running disparity.
// Optional macro TMDS_OUT_REG_EN adds an output register stage (latency 3 instead of 2).
module tmds_encoder #(
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       DE,
  input  logic       hSync,
  input  logic       vSync,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic [9:0] tmds_blue,
  output logic [9:0] tmds_green,
  output logic [9:0] tmds_red
);

  typedef logic signed [CNT_W:0]   disp_t;
  typedef logic signed [CNT_W-1:0] cnt_t;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  localparam disp_t ZERO    = '0;
  localparam disp_t TWO     = disp_t'(2);
  localparam disp_t EIGHT   = disp_t'(8);
  localparam cnt_t  CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam cnt_t  CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [8:0] qm_calc(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    logic [9:0] code;
    unique case (c)
      2'b00:   code = CTRL_00;
      2'b01:   code = CTRL_01;
      2'b10:   code = CTRL_10;
      default: code = CTRL_11;
    endcase
    return code;
  endfunction

  function automatic void encode_sym(
    input  logic       de,
    input  logic [1:0] ctrl,
    input  logic [8:0] qm,
    input  cnt_t       cnt,
    output logic [9:0] sym,
    output cnt_t       cnt_nx
  );
    disp_t cnt_x, diff, bias, sum;
    cnt_x = disp_t'(cnt);
    diff  = (disp_t'(ones8(qm[7:0])) <<< 1) - EIGHT;   // N1q - N0q
    bias  = qm[8] ? TWO : ZERO;
    if (!de) begin
      sym = ctrl_code(ctrl);
      sum = ZERO;
    end else if (cnt_x == ZERO || diff == ZERO) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      sum = qm[8] ? cnt_x + diff : cnt_x - diff;
    end else if ((cnt_x > ZERO && diff > ZERO) || (cnt_x < ZERO && diff < ZERO)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      sum = cnt_x + bias - diff;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      sum = cnt_x + diff - (TWO - bias);
    end
    // Saturate rather than wrap; unreachable for legal CNT_W since |cnt| stays within 10.
    if (sum[CNT_W] != sum[CNT_W-1]) cnt_nx = sum[CNT_W] ? CNT_MIN : CNT_MAX;
    else                            cnt_nx = cnt_t'(sum[CNT_W-1:0]);
  endfunction

  logic [7:0] data_in [3];
  assign data_in[0] = blue;
  assign data_in[1] = green;
  assign data_in[2] = red;

  logic       de_s1_q;
  logic [1:0] ctrl_s1_q;
  logic [8:0] qm_s1_q [3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de_s1_q   <= 1'b0;
      ctrl_s1_q <= 2'b00;
      for (int c = 0; c < 3; c++) qm_s1_q[c] <= '0;
    end else begin
      de_s1_q   <= DE;
      ctrl_s1_q <= {vSync, hSync};
      for (int c = 0; c < 3; c++) qm_s1_q[c] <= qm_calc(data_in[c]);
    end
  end

  logic [9:0] sym_d [3];
  logic [9:0] sym_q [3];
  cnt_t       cnt_d [3];
  cnt_t       cnt_q [3];

  // Only the blue channel carries sync; green and red always send control code 00.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      sym_d[c] = CTRL_00;
      cnt_d[c] = '0;
      encode_sym(de_s1_q, (c == 0) ? ctrl_s1_q : 2'b00, qm_s1_q[c], cnt_q[c],
                 sym_d[c], cnt_d[c]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 3; c++) begin
        sym_q[c] <= CTRL_00;
        cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        sym_q[c] <= sym_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

`ifdef TMDS_OUT_REG_EN
  logic [9:0] out_q [3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 3; c++) out_q[c] <= CTRL_00;
    end else begin
      for (int c = 0; c < 3; c++) out_q[c] <= sym_q[c];
    end
  end

  assign tmds_blue  = out_q[0];
  assign tmds_green = out_q[1];
  assign tmds_red   = out_q[2];
`else
  assign tmds_blue  = sym_q[0];
  assign tmds_green = sym_q[1];
  assign tmds_red   = sym_q[2];
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed hand-computed vectors plus a 1920-pixel reference-model run.
`timescale 1ns/1ps
module tb_tmds_encoder;
`ifdef TMDS_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam logic [9:0] C00 = 10'h354;
  localparam logic [9:0] C01 = 10'h0AB;
  localparam logic [9:0] C10 = 10'h154;
  localparam logic [9:0] C11 = 10'h2AB;

  logic       clk, reset, DE, hSync, vSync;
  logic [7:0] red, green, blue;
  logic [9:0] tmds_blue, tmds_green, tmds_red;
  int tests_run = 0;
  int tests_failed = 0;

  tmds_encoder #(.CNT_W(5)) dut (
    .clk(clk), .reset(reset), .DE(DE), .hSync(hSync), .vSync(vSync),
    .red(red), .green(green), .blue(blue),
    .tmds_blue(tmds_blue), .tmds_green(tmds_green), .tmds_red(tmds_red)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic de, input logic vs, input logic hs,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    DE = de; vSync = vs; hSync = hs; red = r; green = g; blue = b;
  endtask

  // Reference encoder written straight from the DVI algorithm with integer counts.
  task automatic model_sym(input logic de, input logic [1:0] c, input logic [7:0] d,
                           input int cnt_in, output logic [9:0] sym, output int cnt_out);
    int n1d, n1q, n0q;
    logic xn;
    logic [8:0] qm;
    n1d = 0;
    for (int k = 0; k < 8; k++) n1d += int'(d[k]);
    xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm = '0;
    qm[0] = d[0];
    for (int k = 1; k < 8; k++) qm[k] = xn ? ~(qm[k-1] ^ d[k]) : (qm[k-1] ^ d[k]);
    qm[8] = ~xn;
    n1q = 0;
    for (int k = 0; k < 8; k++) n1q += int'(qm[k]);
    n0q = 8 - n1q;
    if (!de) begin
      case (c)
        2'b00:   sym = C00;
        2'b01:   sym = C01;
        2'b10:   sym = C10;
        default: sym = C11;
      endcase
      cnt_out = 0;
    end else if (cnt_in == 0 || n1q == n0q) begin
      if (qm[8]) begin sym = {2'b01, qm[7:0]};  cnt_out = cnt_in + n1q - n0q; end
      else       begin sym = {2'b10, ~qm[7:0]}; cnt_out = cnt_in + n0q - n1q; end
    end else if ((cnt_in > 0 && n1q > n0q) || (cnt_in < 0 && n0q > n1q)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      cnt_out = cnt_in + 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      cnt_out = cnt_in + n1q - n0q - (qm[8] ? 0 : 2);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if ({tmds_blue, tmds_green, tmds_red} !== {C00, C00, C00}) begin
        tests_failed++;
        $display("FAIL reset_hold cycle %0d: got b=%h g=%h r=%h, expected %h on all", i, tmds_blue, tmds_green, tmds_red, C00);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      tests_run++;
      if ({tmds_blue, tmds_green, tmds_red} !== {C00, C00, C00}) begin
        tests_failed++;
        $display("FAIL reset_release cycle %0d: got b=%h g=%h r=%h, expected %h on all", i, tmds_blue, tmds_green, tmds_red, C00);
      end
    end
  endtask

  task automatic test_control();
    logic [1:0] vh [4];
    logic [9:0] exp_b [4];
    vh    = '{2'b01, 2'b11, 2'b10, 2'b00};
    exp_b = '{C01, C11, C10, C00};
    for (int i = 0; i < 4 + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) begin
        tests_run++;
        if ({tmds_blue, tmds_green, tmds_red} !== {exp_b[i-LAT], C00, C00}) begin
          tests_failed++;
          $display("FAIL control vs=%b hs=%b: got b=%h g=%h r=%h, expected b=%h g=%h r=%h", vh[i-LAT][1], vh[i-LAT][0], tmds_blue, tmds_green, tmds_red, exp_b[i-LAT], C00, C00);
        end
      end
      if (i < 4) drive(1'b0, vh[i][1], vh[i][0], 8'hFF, 8'h5A, 8'h00);
      else       drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    end
  endtask

  task automatic test_de_start();
    logic       de_v [6];
    logic [9:0] exp_v [6];
    de_v  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_v = '{C00, C00, 10'h100, 10'h3FF, C00, C00};
    for (int i = 0; i < 6 + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) begin
        tests_run++;
        if (tmds_blue !== exp_v[i-LAT] || tmds_green !== exp_v[i-LAT]) begin
          tests_failed++;
          $display("FAIL de_start step %0d: got b=%h g=%h, expected %h", i - LAT, tmds_blue, tmds_green, exp_v[i-LAT]);
        end
      end
      if (i < 6) drive(de_v[i], 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      else       drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    end
  endtask

  // Red 0xFF, blue 0x00 and green 0x10 streams each walk the disparity counter differently.
  task automatic test_red_ff();
    logic       de_v [6];
    logic [9:0] exp_r [6];
    logic [9:0] exp_b [6];
    logic [9:0] exp_g [6];
    de_v  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_r = '{C00, 10'h200, 10'h0FF, 10'h0FF, 10'h200, C00};
    exp_b = '{C00, 10'h100, 10'h3FF, 10'h100, 10'h3FF, C00};
    exp_g = '{C00, 10'h1F0, 10'h1F0, 10'h1F0, 10'h1F0, C00};
    for (int i = 0; i < 6 + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) begin
        tests_run++;
        if ({tmds_blue, tmds_green, tmds_red} !== {exp_b[i-LAT], exp_g[i-LAT], exp_r[i-LAT]}) begin
          tests_failed++;
          $display("FAIL red_ff step %0d: got b=%h g=%h r=%h, expected b=%h g=%h r=%h", i - LAT, tmds_blue, tmds_green, tmds_red, exp_b[i-LAT], exp_g[i-LAT], exp_r[i-LAT]);
        end
      end
      if (i < 6) drive(de_v[i], 1'b0, 1'b0, 8'hFF, 8'h10, 8'h00);
      else       drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    end
  endtask

  task automatic test_back_to_back();
    logic [29:0] exp_q [$];
    int cnt_b, cnt_g, cnt_r;
    cnt_b = 0; cnt_g = 0; cnt_r = 0;
    for (int i = 0; i < 1920 + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) begin
        logic [29:0] e;
        e = exp_q.pop_front();
        tests_run++;
        if ({tmds_blue, tmds_green, tmds_red} !== e) begin
          tests_failed++;
          $display("FAIL back_to_back pixel %0d: got b=%h g=%h r=%h, expected b=%h g=%h r=%h", i - LAT, tmds_blue, tmds_green, tmds_red, e[29:20], e[19:10], e[9:0]);
        end
      end
      if (i < 1920) begin
        int p;
        logic de_i, hs_i, vs_i;
        logic [7:0] b_i, g_i, r_i;
        logic [9:0] sb, sg, sr;
        p    = i % 480;
        de_i = (p < 470);
        hs_i = (p >= 472 && p < 476);
        vs_i = ((i / 480) == 2);
        b_i  = i[0] ? 8'hEF : 8'h10;
        g_i  = 8'(i * 37 + 11);
        r_i  = 8'(i ^ (i >> 2));
        drive(de_i, vs_i, hs_i, r_i, g_i, b_i);
        model_sym(de_i, {vs_i, hs_i}, b_i, cnt_b, sb, cnt_b);
        model_sym(de_i, 2'b00, g_i, cnt_g, sg, cnt_g);
        model_sym(de_i, 2'b00, r_i, cnt_r, sr, cnt_r);
        exp_q.push_back({sb, sg, sr});
      end else begin
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      end
    end
  endtask

  task automatic test_reset_midline();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00);
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({tmds_blue, tmds_green, tmds_red} !== {C00, C00, C00}) begin
      tests_failed++;
      $display("FAIL reset_async: got b=%h g=%h r=%h, expected %h on all", tmds_blue, tmds_green, tmds_red, C00);
    end
    @(negedge clk);
    tests_run++;
    if ({tmds_blue, tmds_green, tmds_red} !== {C00, C00, C00}) begin
      tests_failed++;
      $display("FAIL reset_midline_hold: got b=%h g=%h r=%h, expected %h on all", tmds_blue, tmds_green, tmds_red, C00);
    end
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00);
    for (int i = 1; i <= LAT + 1; i++) begin
      logic [29:0] e;
      @(negedge clk);
      if (i < LAT)       e = {C00, C00, C00};
      else if (i == LAT) e = {10'h100, 10'h100, 10'h200};
      else               e = {10'h3FF, 10'h3FF, 10'h0FF};
      tests_run++;
      if ({tmds_blue, tmds_green, tmds_red} !== e) begin
        tests_failed++;
        $display("FAIL reset_restart cycle %0d: got b=%h g=%h r=%h, expected b=%h g=%h r=%h", i, tmds_blue, tmds_green, tmds_red, e[29:20], e[19:10], e[9:0]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (LAT + 1) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_control();
    test_de_start();
    test_red_ff();
    test_back_to_back();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
